// File: rtl/watch_alarm.sv
// watch_alarm: daily alarm controller. Compares the running watch time with a
// programmed alarm time and drives the buzzer with snooze, stop and auto-timeout.
module watch_alarm #(
  parameter int P_SEC_BIT    = 6,
  parameter int P_MIN_BIT    = 6,
  parameter int P_HOUR_BIT   = 5,
  parameter int P_RING_SEC   = 60,
  parameter int P_SNOOZE_SEC = 300,
  parameter int P_SNOOZE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run_en,
  input  logic                  i_sec_tick,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic                  i_alarm_en,
  input  logic                  i_set,
  input  logic [P_HOUR_BIT-1:0] i_alarm_hour,
  input  logic [P_MIN_BIT-1:0]  i_alarm_min,
  input  logic                  i_snooze,
  input  logic                  i_stop,
  output logic                  o_ring,
  output logic [1:0]            o_state,
  output logic [3:0]            o_snooze_num,
  output logic                  o_set_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [P_HOUR_BIT-1:0]   alm_hour, alm_hour_n;
  logic [P_MIN_BIT-1:0]    alm_min, alm_min_n;
  logic [7:0]              ring_cnt, ring_cnt_n;
  logic [11:0]             snooze_cnt, snooze_cnt_n;
  logic [3:0]              snooze_num, snooze_num_n;
  logic                    match_q, match_q_n;
  logic                    ring_q, ring_n;
  logic                    set_err_q, set_err_n;

  logic match;
  logic trigger;
  logic tick_en;
  logic ring_timeout;
  logic set_valid;
  logic set_same_busy;
  logic set_accept;
  logic set_reject;

  // Time comparison, edge detect and request decoding shared by the next-state logic
  always_comb begin
    match         = i_run_en && (i_hour == alm_hour) && (i_min == alm_min) && (i_sec == '0);
    trigger       = match && !match_q;
    tick_en       = i_sec_tick && i_run_en;
    ring_timeout  = tick_en && (ring_cnt == 8'(P_RING_SEC - 1));
    set_valid     = (i_alarm_hour <= P_HOUR_BIT'(23)) && (i_alarm_min <= P_MIN_BIT'(59));
    // Re-programming the same alarm while it is active must not restart the event
    set_same_busy = ((state == RINGING) || (state == SNOOZE)) &&
                    (i_alarm_hour == alm_hour) && (i_alarm_min == alm_min);
    set_accept    = i_set && set_valid && !set_same_busy;
    set_reject    = i_set && !set_valid;
  end

  // Next-state, counter and output decisions in priority order
  always_comb begin
    state_n      = state;
    alm_hour_n   = alm_hour;
    alm_min_n    = alm_min;
    ring_cnt_n   = ring_cnt;
    snooze_cnt_n = snooze_cnt;
    snooze_num_n = snooze_num;
    set_err_n    = 1'b0;
    match_q_n    = i_run_en ? match : match_q;

    if (!i_alarm_en) begin
      state_n      = IDLE;
      ring_cnt_n   = '0;
      snooze_cnt_n = '0;
      snooze_num_n = '0;
    end else if (set_accept) begin
      alm_hour_n   = i_alarm_hour;
      alm_min_n    = i_alarm_min;
      state_n      = ARMED;
      ring_cnt_n   = '0;
      snooze_cnt_n = '0;
      snooze_num_n = '0;
      // Seed the edge detector with the new alarm so setting it to the current
      // second-zero instant does not look like a fresh rising edge
      if (i_run_en) begin
        match_q_n = (i_hour == i_alarm_hour) && (i_min == i_alarm_min) && (i_sec == '0);
      end
    end else if (set_reject) begin
      set_err_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARMED;
        end
        ARMED: begin
          if (trigger) begin
            state_n    = RINGING;
            ring_cnt_n = '0;
          end
        end
        RINGING: begin
          if (i_stop) begin
            state_n      = ARMED;
            ring_cnt_n   = '0;
            snooze_num_n = '0;
          end else if (i_snooze || ring_timeout) begin
            ring_cnt_n = '0;
            if (snooze_num < 4'(P_SNOOZE_MAX)) begin
              state_n      = SNOOZE;
              snooze_num_n = snooze_num + 4'd1;
              snooze_cnt_n = 12'(P_SNOOZE_SEC);
            end else begin
              state_n      = ARMED;
              snooze_num_n = '0;
            end
          end else if (tick_en) begin
            ring_cnt_n = ring_cnt + 8'd1;
          end
        end
        SNOOZE: begin
          if (i_stop) begin
            state_n      = ARMED;
            snooze_cnt_n = '0;
            snooze_num_n = '0;
          end else if (tick_en) begin
            if (snooze_cnt <= 12'd1) begin
              state_n      = RINGING;
              snooze_cnt_n = '0;
              ring_cnt_n   = '0;
            end else begin
              snooze_cnt_n = snooze_cnt - 12'd1;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    ring_n = (state_n == RINGING);
  end

  // State, alarm registers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alm_hour   <= '0;
      alm_min    <= '0;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      snooze_num <= '0;
      match_q    <= 1'b0;
      ring_q     <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state      <= state_n;
      alm_hour   <= alm_hour_n;
      alm_min    <= alm_min_n;
      ring_cnt   <= ring_cnt_n;
      snooze_cnt <= snooze_cnt_n;
      snooze_num <= snooze_num_n;
      match_q    <= match_q_n;
      ring_q     <= ring_n;
      set_err_q  <= set_err_n;
    end
  end

  assign o_state      = state;
  assign o_ring       = ring_q;
  assign o_snooze_num = snooze_num;
  assign o_set_err    = set_err_q;

endmodule

// File: tb/tb_watch_alarm.sv
// tb_watch_alarm: directed self-checking bench for the daily alarm controller.
module tb_watch_alarm;

  logic       clk;
  logic       reset;
  logic       i_run_en;
  logic       i_sec_tick;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic       i_alarm_en;
  logic       i_set;
  logic [4:0] i_alarm_hour;
  logic [5:0] i_alarm_min;
  logic       i_snooze;
  logic       i_stop;
  logic       o_ring;
  logic [1:0] o_state;
  logic [3:0] o_snooze_num;
  logic       o_set_err;

  int assert_count = 0;
  int fail_count   = 0;

  watch_alarm dut (
    .clk          (clk),
    .reset        (reset),
    .i_run_en     (i_run_en),
    .i_sec_tick   (i_sec_tick),
    .i_sec        (i_sec),
    .i_min        (i_min),
    .i_hour       (i_hour),
    .i_alarm_en   (i_alarm_en),
    .i_set        (i_set),
    .i_alarm_hour (i_alarm_hour),
    .i_alarm_min  (i_alarm_min),
    .i_snooze     (i_snooze),
    .i_stop       (i_stop),
    .o_ring       (o_ring),
    .o_state      (o_state),
    .o_snooze_num (o_snooze_num),
    .o_set_err    (o_set_err)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the active edge
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the current watch time
  task automatic applyStimulus(input int hour, input int minute, input int second);
    i_hour = 5'(hour);
    i_min  = 6'(minute);
    i_sec  = 6'(second);
  endtask

  // One second tick followed by an idle cycle, repeated n times
  task automatic ticks(input int n);
    repeat (n) begin
      i_sec_tick = 1'b1;
      cyc();
      i_sec_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic pulse_snooze();
    i_snooze = 1'b1;
    cyc();
    i_snooze = 1'b0;
  endtask

  task automatic pulse_set(input int hour, input int minute);
    i_alarm_hour = 5'(hour);
    i_alarm_min  = 6'(minute);
    i_set        = 1'b1;
    cyc();
    i_set        = 1'b0;
  endtask

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset        = 1'b1;
    i_run_en     = 1'b1;
    i_sec_tick   = 1'b0;
    i_alarm_en   = 1'b0;
    i_set        = 1'b0;
    i_alarm_hour = '0;
    i_alarm_min  = '0;
    i_snooze     = 1'b0;
    i_stop       = 1'b0;
    applyStimulus(12, 0, 5);
    cyc(3);
    reset = 1'b0;
    cyc(2);
    $display("[TB] reset and arming");
    checkOutput("reset_state", o_state, 0);
    checkOutput("reset_ring", o_ring, 0);
    checkOutput("reset_num", o_snooze_num, 0);
    checkOutput("reset_err", o_set_err, 0);

    i_alarm_en = 1'b1;
    cyc();
    checkOutput("arm_state", o_state, 1);
    pulse_set(7, 30);
    checkOutput("set_valid_err", o_set_err, 0);
    checkOutput("set_valid_state", o_state, 1);

    $display("[TB] trigger at 07:30:00");
    applyStimulus(7, 29, 59);
    ticks(2);
    checkOutput("pre_match_state", o_state, 1);
    applyStimulus(7, 30, 0);
    i_sec_tick = 1'b1;
    #1;
    checkOutput("trig_cycle_ring", o_ring, 0);
    cyc();
    i_sec_tick = 1'b0;
    checkOutput("trig_state", o_state, 2);
    checkOutput("trig_ring", o_ring, 1);
    applyStimulus(7, 30, 1);
    cyc();

    $display("[TB] manual snoozes");
    pulse_snooze();
    checkOutput("snz1_state", o_state, 3);
    checkOutput("snz1_num", o_snooze_num, 1);
    checkOutput("snz1_ring", o_ring, 0);
    pulse_snooze();
    checkOutput("snz_ignored_num", o_snooze_num, 1);
    ticks(299);
    checkOutput("snz1_299_state", o_state, 3);
    ticks(1);
    checkOutput("snz1_end_state", o_state, 2);
    checkOutput("snz1_end_ring", o_ring, 1);
    checkOutput("snz1_end_num", o_snooze_num, 1);
    pulse_snooze();
    checkOutput("snz2_num", o_snooze_num, 2);
    ticks(300);
    checkOutput("snz2_end_state", o_state, 2);
    pulse_snooze();
    checkOutput("snz3_num", o_snooze_num, 3);
    ticks(300);
    checkOutput("snz3_end_state", o_state, 2);
    pulse_snooze();
    checkOutput("snz4_state", o_state, 1);
    checkOutput("snz4_num", o_snooze_num, 0);
    checkOutput("snz4_ring", o_ring, 0);

    $display("[TB] ring timeout");
    applyStimulus(7, 30, 0);
    cyc();
    checkOutput("retrig_state", o_state, 2);
    ticks(59);
    checkOutput("ring_59_state", o_state, 2);
    ticks(1);
    checkOutput("timeout_state", o_state, 3);
    checkOutput("timeout_num", o_snooze_num, 1);
    i_stop   = 1'b1;
    i_snooze = 1'b1;
    cyc();
    i_stop   = 1'b0;
    i_snooze = 1'b0;
    checkOutput("stop_snz_state", o_state, 1);
    checkOutput("stop_snz_num", o_snooze_num, 0);
    cyc(20);
    checkOutput("hold_single_state", o_state, 1);
    checkOutput("hold_single_ring", o_ring, 0);

    $display("[TB] stop plus snooze while ringing");
    applyStimulus(7, 30, 1);
    cyc();
    applyStimulus(7, 30, 0);
    cyc();
    checkOutput("retrig2_state", o_state, 2);
    i_stop   = 1'b1;
    i_snooze = 1'b1;
    cyc();
    i_stop   = 1'b0;
    i_snooze = 1'b0;
    checkOutput("ring_stop_state", o_state, 1);
    checkOutput("ring_stop_num", o_snooze_num, 0);
    checkOutput("ring_stop_ring", o_ring, 0);

    $display("[TB] invalid set values");
    pulse_set(24, 0);
    checkOutput("bad_hour_err", o_set_err, 1);
    checkOutput("bad_hour_state", o_state, 1);
    cyc();
    checkOutput("err_pulse_end", o_set_err, 0);
    pulse_set(7, 60);
    checkOutput("bad_min_err", o_set_err, 1);
    applyStimulus(7, 30, 1);
    cyc();
    applyStimulus(7, 30, 0);
    cyc();
    checkOutput("alarm_kept_state", o_state, 2);
    i_alarm_en = 1'b0;
    cyc();
    checkOutput("en_off_state", o_state, 0);
    checkOutput("en_off_ring", o_ring, 0);

    $display("[TB] run enable gating");
    i_alarm_en = 1'b1;
    cyc();
    applyStimulus(7, 30, 1);
    cyc();
    i_run_en = 1'b0;
    applyStimulus(7, 30, 0);
    cyc(3);
    checkOutput("run_off_state", o_state, 1);
    i_run_en = 1'b1;
    cyc();
    checkOutput("run_on_state", o_state, 2);
    i_run_en = 1'b0;
    ticks(70);
    checkOutput("frozen_state", o_state, 2);
    checkOutput("frozen_ring", o_ring, 1);
    i_run_en = 1'b1;

    $display("[TB] reset during snooze");
    pulse_snooze();
    checkOutput("pre_reset_state", o_state, 3);
    reset = 1'b1;
    cyc();
    checkOutput("snz_reset_state", o_state, 0);
    checkOutput("snz_reset_num", o_snooze_num, 0);
    checkOutput("snz_reset_ring", o_ring, 0);
    reset = 1'b0;

    $display("[TB] boundary alarm 23:59");
    cyc();
    checkOutput("rearm_state", o_state, 1);
    pulse_set(23, 59);
    checkOutput("set_2359_err", o_set_err, 0);
    applyStimulus(23, 58, 59);
    cyc();
    applyStimulus(23, 59, 0);
    cyc();
    checkOutput("trig_2359_state", o_state, 2);
    checkOutput("trig_2359_ring", o_ring, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
